riscv_jtag_dtm_0p11: RTL and testbench
======================================

Name: riscv_jtag_dtm_0p11

Overview:
- JTAG Debug Transport Module (DTM) per RISC-V External Debug Support v0.11. Sits directly upstream of the Debug Module and drives its DMI request/response port.
- Implements the IEEE 1149.1 TAP controller, the IR, and the IDCODE, BYPASS, DTMCONTROL and DBUS data registers.
- Converts DBUS Update-DR scans into 41-bit DMI requests and returns 36-bit DMI responses on the next DBUS capture.
- Runs entirely in the TCK domain. Clock-domain crossing is owned by the Debug Module.

Parameters:
- IDCODE, 32'h1000_0A6D: value of the IDCODE register; bit0 is forced to 1.
- ABITS, 5: DBUS address width. Fixed for the Debug Module; reported in DTMCONTROL.
- IDLE_HINT, 3'd5: DTMCONTROL.idle field value.

Ports:
- clk, input, 1: JTAG TCK.
- rst_n, input, 1: asynchronous active-low reset (TRST_N combined with power-on reset).
- tms, input, 1: JTAG TMS, sampled on rising clk.
- tdi, input, 1: JTAG TDI, sampled on rising clk.
- tdo, output, 1: JTAG TDO, updated on falling clk.
- tdo_en, output, 1: TDO drive enable; high only in Shift-IR/Shift-DR, updated on falling clk.
- dtm_req_valid, output, 1: DMI request valid.
- dtm_req_ready, input, 1: DMI request ready.
- dtm_req_bits, output, 41: {addr[40:36], data[35:2], op[1:0]}.
- dtm_resp_valid, input, 1: DMI response valid.
- dtm_resp_ready, output, 1: DMI response ready.
- dtm_resp_bits, input, 36: {data[35:2], resp[1:0]}.

Behaviour:
- Reset values: TAP=Test-Logic-Reset, IR=5'h01 (IDCODE), tdo=0, tdo_en=0, dtm_req_valid=0, dtm_req_bits=0, dtm_resp_ready=0, dbusstat=0, busy=0, resp capture register=0.
- TAP FSM: standard 16 states with standard TMS transitions.
  - Five TMS=1 clocks from any state reach Test-Logic-Reset.
  - Test-Logic-Reset sets IR=IDCODE and clears dbusstat. It does not cancel an outstanding DMI request.
- IR: 5 bits.
  - Capture-IR loads 5'b00001; LSB shifts out first; Update-IR commits.
  - Codes: 0x01 IDCODE, 0x10 DTMCONTROL, 0x11 DBUS, 0x1F BYPASS. Any other code selects BYPASS.
- DR shift: LSB first; tdi enters the MSB. BYPASS is 1 bit and captures 0.
- DTMCONTROL (32 bits):
  - Capture fields: [16] dbusreset=0, [14:13] abits_hi=ABITS[5:4], [12:10] idle=IDLE_HINT, [9:8] dbusstat, [7:4] abits_lo=ABITS[3:0], [3:0] version=0.
  - Update-DR with bit16=1 clears dbusstat. All other bits are read-only.
- DBUS (41 bits): {addr[40:36], data[35:2], op[1:0]}.
  - Capture-DR loads {last_addr, resp_data[33:0], status}.
  - status = dbusstat if nonzero; else 2'd3 if busy; else the resp field of the last response.
- DBUS Update-DR:
  - If dbusstat != 0: ignore the scan.
  - Else if busy: set dbusstat=3 (sticky) and ignore the scan.
  - Else if op==0 (nop): no request; last_addr is unchanged.
  - Else (op 1 or 2): on the same clk edge, load dtm_req_bits from the shift register, set dtm_req_valid=1, busy=1, last_addr=addr. op 3 is forwarded unchanged.
- Request handshake:
  - dtm_req_valid and dtm_req_bits are held stable until dtm_req_valid & dtm_req_ready, which clears valid the next cycle.
- Response handshake:
  - dtm_resp_ready=1 while busy.
  - On dtm_resp_valid & dtm_resp_ready: latch resp_data/resp and clear busy.
  - A response arriving in the same cycle as a request handshake is accepted.
- Simultaneous Capture-DR and response arrival: the capture uses the pre-edge state, so it reports busy (status 3).
- Mid-operation reset (rst_n low): all state returns to reset values immediately; an in-flight request is dropped.
- tdo shows shift-register LSB (IR or selected DR) on falling clk while in Shift-*; otherwise 0 with tdo_en=0.

Decomposition:
- riscv_dtm_pkg holds:
  - tap_state_e enum (16 states);
  - IR code constants IR_IDCODE, IR_DTMCONTROL, IR_DBUS, IR_BYPASS;
  - DBUS field widths (DBUS_W=41, RESP_W=36);
  - dbus status codes (OK=0, FAIL=2, BUSY=3).
- Sub-module riscv_jtag_tap: TAP FSM only. Outputs state decode strobes: capture_dr, shift_dr, update_dr, capture_ir, shift_ir, update_ir, test_logic_reset.

Test Plan:
- Reset, 5x TMS=1, then scan DR with IR untouched: 32 bits out = IDCODE, e.g. 0x1000_0A6D LSB first; tdo_en high only during Shift-DR.
- IR=0x10, scan DR 32 bits of 0: read 0x0000_1450 (idle=5, abits_lo=5, version=0).
- IR=0x11, scan addr=0x10, data=0, op=1:
  - dtm_req_bits=0x100_0000_0001 asserted after Update-DR and held while dtm_req_ready=0 for 3 cycles;
  - respond data=0x3_0000_0004, resp=0;
  - next DBUS scan captures {0x10, 0x3_0000_0004, 2'b00}.
- Withhold the response, issue second DBUS op=2:
  - no new request;
  - captures show status 3 (sticky);
  - after the response, captures still show 3 until DTMCONTROL write with bit16=1, after which status returns 0.
- DBUS scan with op=0 while idle: dtm_req_valid stays 0; capture returns the previous response unchanged.
- Assert rst_n low while dtm_req_valid=1: valid=0, IR=IDCODE, busy=0 immediately; the next IDCODE scan is correct.

Source files
------------

// File: rtl/riscv_dtm_pkg.sv
// Shared types and constants for the RISC-V v0.11 JTAG DTM.
package riscv_dtm_pkg;

   typedef enum logic [3:0] {
      TAP_TLR,
      TAP_RTI,
      TAP_SEL_DR,
      TAP_CAP_DR,
      TAP_SHIFT_DR,
      TAP_EXIT1_DR,
      TAP_PAUSE_DR,
      TAP_EXIT2_DR,
      TAP_UPD_DR,
      TAP_SEL_IR,
      TAP_CAP_IR,
      TAP_SHIFT_IR,
      TAP_EXIT1_IR,
      TAP_PAUSE_IR,
      TAP_EXIT2_IR,
      TAP_UPD_IR
   } tap_state_e;

   // Data register selected by the current IR contents
   typedef enum logic [1:0] {
      DR_BYPASS,
      DR_IDCODE,
      DR_DTMCONTROL,
      DR_DBUS
   } dr_sel_e;

   localparam logic [4:0] IR_IDCODE     = 5'h01;
   localparam logic [4:0] IR_DTMCONTROL = 5'h10;
   localparam logic [4:0] IR_DBUS       = 5'h11;
   localparam logic [4:0] IR_BYPASS     = 5'h1F;

   localparam int DBUS_W = 41;
   localparam int RESP_W = 36;

   localparam logic [1:0] DBUS_OK   = 2'd0;
   localparam logic [1:0] DBUS_FAIL = 2'd2;
   localparam logic [1:0] DBUS_BUSY = 2'd3;

endpackage

// File: rtl/riscv_jtag_tap.sv
// IEEE 1149.1 TAP controller state machine with per-state action strobes.
module riscv_jtag_tap
   import riscv_dtm_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic tms,
   output logic capture_dr,
   output logic shift_dr,
   output logic update_dr,
   output logic capture_ir,
   output logic shift_ir,
   output logic update_ir,
   output logic test_logic_reset
);

   tap_state_e state_q, state_d;

   // State register, reset to Test-Logic-Reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= TAP_TLR;
      else        state_q <= state_d;
   end

   // Standard TMS-driven transitions and state decode strobes
   always_comb begin
      state_d = state_q;
      case (state_q)
         TAP_TLR:      state_d = tms ? TAP_TLR      : TAP_RTI;
         TAP_RTI:      state_d = tms ? TAP_SEL_DR   : TAP_RTI;
         TAP_SEL_DR:   state_d = tms ? TAP_SEL_IR   : TAP_CAP_DR;
         TAP_CAP_DR:   state_d = tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
         TAP_SHIFT_DR: state_d = tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
         TAP_EXIT1_DR: state_d = tms ? TAP_UPD_DR   : TAP_PAUSE_DR;
         TAP_PAUSE_DR: state_d = tms ? TAP_EXIT2_DR : TAP_PAUSE_DR;
         TAP_EXIT2_DR: state_d = tms ? TAP_UPD_DR   : TAP_SHIFT_DR;
         TAP_UPD_DR:   state_d = tms ? TAP_SEL_DR   : TAP_RTI;
         TAP_SEL_IR:   state_d = tms ? TAP_TLR      : TAP_CAP_IR;
         TAP_CAP_IR:   state_d = tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
         TAP_SHIFT_IR: state_d = tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
         TAP_EXIT1_IR: state_d = tms ? TAP_UPD_IR   : TAP_PAUSE_IR;
         TAP_PAUSE_IR: state_d = tms ? TAP_EXIT2_IR : TAP_PAUSE_IR;
         TAP_EXIT2_IR: state_d = tms ? TAP_UPD_IR   : TAP_SHIFT_IR;
         TAP_UPD_IR:   state_d = tms ? TAP_SEL_DR   : TAP_RTI;
         default:      state_d = TAP_TLR;
      endcase
      capture_dr       = (state_q == TAP_CAP_DR);
      shift_dr         = (state_q == TAP_SHIFT_DR);
      update_dr        = (state_q == TAP_UPD_DR);
      capture_ir       = (state_q == TAP_CAP_IR);
      shift_ir         = (state_q == TAP_SHIFT_IR);
      update_ir        = (state_q == TAP_UPD_IR);
      test_logic_reset = (state_q == TAP_TLR);
   end

endmodule

// File: rtl/riscv_jtag_dtm_0p11.sv
// JTAG Debug Transport Module: IR, IDCODE/BYPASS/DTMCONTROL/DBUS registers
// and the DMI request/response handshake, all in the TCK domain.
module riscv_jtag_dtm_0p11
   import riscv_dtm_pkg::*;
#(
   parameter logic [31:0] IDCODE    = 32'h1000_0A6D,
   parameter int unsigned ABITS     = 5,
   parameter logic [2:0]  IDLE_HINT = 3'd5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              tms,
   input  logic              tdi,
   output logic              tdo,
   output logic              tdo_en,
   output logic              dtm_req_valid,
   input  logic              dtm_req_ready,
   output logic [DBUS_W-1:0] dtm_req_bits,
   input  logic              dtm_resp_valid,
   output logic              dtm_resp_ready,
   input  logic [RESP_W-1:0] dtm_resp_bits
);

   localparam logic [5:0] ABITS_V = 6'(ABITS);

   logic capture_dr, shift_dr, update_dr;
   logic capture_ir, shift_ir, update_ir, test_logic_reset;

   riscv_jtag_tap u_tap (
      .clk              (clk),
      .rst_n            (rst_n),
      .tms              (tms),
      .capture_dr       (capture_dr),
      .shift_dr         (shift_dr),
      .update_dr        (update_dr),
      .capture_ir       (capture_ir),
      .shift_ir         (shift_ir),
      .update_ir        (update_ir),
      .test_logic_reset (test_logic_reset)
   );

   logic [4:0]        ir_q, ir_d;
   logic [4:0]        ir_shift_q, ir_shift_d;
   logic [DBUS_W-1:0] dr_shift_q, dr_shift_d;
   logic [1:0]        dbusstat_q, dbusstat_d;
   logic              busy_q, busy_d;
   logic              req_valid_q, req_valid_d;
   logic [DBUS_W-1:0] req_bits_q, req_bits_d;
   logic [33:0]       resp_data_q, resp_data_d;
   logic [1:0]        resp_q, resp_d;
   logic [4:0]        last_addr_q, last_addr_d;
   logic              tdo_q, tdo_d;
   logic              tdo_en_q, tdo_en_d;

   dr_sel_e     dr_sel;
   logic [1:0]  dbus_status;
   logic [31:0] dtmcs_cap;

   // Map the committed IR to a data register; unknown codes fall back to BYPASS
   always_comb begin
      dr_sel = DR_BYPASS;
      case (ir_q)
         IR_IDCODE:     dr_sel = DR_IDCODE;
         IR_DTMCONTROL: dr_sel = DR_DTMCONTROL;
         IR_DBUS:       dr_sel = DR_DBUS;
         default:       dr_sel = DR_BYPASS;
      endcase
   end

   // Status reported on DBUS capture: sticky error wins, then busy, then last resp
   always_comb begin
      if (dbusstat_q != DBUS_OK) dbus_status = dbusstat_q;
      else if (busy_q)           dbus_status = DBUS_BUSY;
      else                       dbus_status = resp_q;
      dtmcs_cap = {15'd0, 1'b0, 1'b0, ABITS_V[5:4], IDLE_HINT, dbusstat_q,
                   ABITS_V[3:0], 4'd0};
   end

   // Next-state logic for IR, data registers and the DMI handshake
   always_comb begin
      ir_d        = ir_q;
      ir_shift_d  = ir_shift_q;
      dr_shift_d  = dr_shift_q;
      dbusstat_d  = dbusstat_q;
      busy_d      = busy_q;
      req_valid_d = req_valid_q;
      req_bits_d  = req_bits_q;
      resp_data_d = resp_data_q;
      resp_d      = resp_q;
      last_addr_d = last_addr_q;

      if (capture_ir) ir_shift_d = 5'b00001;
      if (shift_ir)   ir_shift_d = {tdi, ir_shift_q[4:1]};
      if (update_ir)  ir_d = ir_shift_q;

      if (capture_dr) begin
         case (dr_sel)
            DR_IDCODE:     dr_shift_d = {9'd0, IDCODE[31:1], 1'b1};
            DR_DTMCONTROL: dr_shift_d = {9'd0, dtmcs_cap};
            DR_DBUS:       dr_shift_d = {last_addr_q, resp_data_q, dbus_status};
            default:       dr_shift_d = '0;
         endcase
      end

      // Each register shifts over its own length so tdi lands in its MSB
      if (shift_dr) begin
         case (dr_sel)
            DR_IDCODE, DR_DTMCONTROL: dr_shift_d[31:0] = {tdi, dr_shift_q[31:1]};
            DR_DBUS:                  dr_shift_d = {tdi, dr_shift_q[DBUS_W-1:1]};
            default:                  dr_shift_d[0] = tdi;
         endcase
      end

      if (req_valid_q && dtm_req_ready) req_valid_d = 1'b0;

      if (dtm_resp_valid && busy_q) begin
         resp_data_d = dtm_resp_bits[RESP_W-1:2];
         resp_d      = dtm_resp_bits[1:0];
         busy_d      = 1'b0;
      end

      if (update_dr) begin
         if (dr_sel == DR_DTMCONTROL && dr_shift_q[16]) begin
            dbusstat_d = DBUS_OK;
         end else if (dr_sel == DR_DBUS) begin
            if (dbusstat_q != DBUS_OK) begin
               // scan dropped until the host clears the sticky error
            end else if (busy_q) begin
               dbusstat_d = DBUS_BUSY;
            end else if (dr_shift_q[1:0] != 2'd0) begin
               req_bits_d  = dr_shift_q;
               req_valid_d = 1'b1;
               busy_d      = 1'b1;
               last_addr_d = dr_shift_q[DBUS_W-1:DBUS_W-5];
            end
         end
      end

      // Test-Logic-Reset leaves any outstanding DMI transaction alone
      if (test_logic_reset) begin
         ir_d       = IR_IDCODE;
         dbusstat_d = DBUS_OK;
      end
   end

   // Rising-edge state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ir_q        <= IR_IDCODE;
         ir_shift_q  <= '0;
         dr_shift_q  <= '0;
         dbusstat_q  <= DBUS_OK;
         busy_q      <= 1'b0;
         req_valid_q <= 1'b0;
         req_bits_q  <= '0;
         resp_data_q <= '0;
         resp_q      <= '0;
         last_addr_q <= '0;
      end else begin
         ir_q        <= ir_d;
         ir_shift_q  <= ir_shift_d;
         dr_shift_q  <= dr_shift_d;
         dbusstat_q  <= dbusstat_d;
         busy_q      <= busy_d;
         req_valid_q <= req_valid_d;
         req_bits_q  <= req_bits_d;
         resp_data_q <= resp_data_d;
         resp_q      <= resp_d;
         last_addr_q <= last_addr_d;
      end
   end

   // TDO source: shift-register LSB while shifting, otherwise quiet
   always_comb begin
      tdo_en_d = shift_ir | shift_dr;
      if (shift_ir)      tdo_d = ir_shift_q[0];
      else if (shift_dr) tdo_d = dr_shift_q[0];
      else               tdo_d = 1'b0;
   end

   // TDO launched on the falling edge so the host samples it on the next rise
   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tdo_q    <= 1'b0;
         tdo_en_q <= 1'b0;
      end else begin
         tdo_q    <= tdo_d;
         tdo_en_q <= tdo_en_d;
      end
   end

   assign tdo            = tdo_q;
   assign tdo_en         = tdo_en_q;
   assign dtm_req_valid  = req_valid_q;
   assign dtm_req_bits   = req_bits_q;
   assign dtm_resp_ready = busy_q;

endmodule

// File: tb/tb_riscv_jtag_dtm_0p11.sv
// Directed bench for the JTAG DTM: TAP scans, DTMCONTROL, DBUS and DMI handshake.
module tb_riscv_jtag_dtm_0p11;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        tms = 1'b1;
   logic        tdi = 1'b0;
   logic        tdo, tdo_en;
   logic        dtm_req_valid;
   logic        dtm_req_ready = 1'b0;
   logic [40:0] dtm_req_bits;
   logic        dtm_resp_valid = 1'b0;
   logic        dtm_resp_ready;
   logic [35:0] dtm_resp_bits = '0;

   int checks = 0;
   int passes = 0;

   riscv_jtag_dtm_0p11 dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .tms            (tms),
      .tdi            (tdi),
      .tdo            (tdo),
      .tdo_en         (tdo_en),
      .dtm_req_valid  (dtm_req_valid),
      .dtm_req_ready  (dtm_req_ready),
      .dtm_req_bits   (dtm_req_bits),
      .dtm_resp_valid (dtm_resp_valid),
      .dtm_resp_ready (dtm_resp_ready),
      .dtm_resp_bits  (dtm_resp_bits)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got === exp) begin
         passes++;
         $display("ok   %-14s got=0x%0h", tag, got);
      end else begin
         $display("FAIL %-14s got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // One TCK: sample TDO after the falling edge, drive TMS/TDI, let the rising edge act
   task automatic step(input logic tms_v, input logic tdi_v,
                       output logic tdo_s, output logic en_s);
      @(negedge clk);
      #1;
      tdo_s = tdo;
      en_s  = tdo_en;
      tms   = tms_v;
      tdi   = tdi_v;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      logic t, e;
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, t, e);
   endtask

   task automatic tap_reset();
      logic t, e;
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, t, e);
      step(1'b0, 1'b0, t, e);
   endtask

   // From Run-Test/Idle, scan n DR bits and return to Run-Test/Idle
   task automatic scan_dr(input int n, input logic [40:0] din,
                          output logic [40:0] dout, output int en_err);
      logic t, e;
      dout = '0;
      en_err = 0;
      step(1'b1, 1'b0, t, e); if (e) en_err++;
      step(1'b0, 1'b0, t, e); if (e) en_err++;
      step(1'b0, 1'b0, t, e); if (e) en_err++;
      for (int i = 0; i < n; i++) begin
         step(i == n - 1, din[i], t, e);
         dout[i] = t;
         if (!e) en_err++;
      end
      step(1'b1, 1'b0, t, e); if (e) en_err++;
      step(1'b0, 1'b0, t, e); if (e) en_err++;
   endtask

   task automatic scan_ir(input logic [4:0] din, output logic [4:0] dout);
      logic t, e;
      dout = '0;
      step(1'b1, 1'b0, t, e);
      step(1'b1, 1'b0, t, e);
      step(1'b0, 1'b0, t, e);
      step(1'b0, 1'b0, t, e);
      for (int i = 0; i < 5; i++) begin
         step(i == 4, din[i], t, e);
         dout[i] = t;
      end
      step(1'b1, 1'b0, t, e);
      step(1'b0, 1'b0, t, e);
   endtask

   initial begin
      logic [40:0] dout;
      logic [4:0]  irout;
      int          en_err;
      logic [40:0] v1, v2, v3, v4;

      v1 = {5'h10, 34'h0, 2'd1};
      v2 = {5'h07, 34'h0_0000_00AA, 2'd2};
      v3 = {5'h09, 34'h0_0000_0055, 2'd2};
      v4 = {5'h03, 34'h0_0000_0011, 2'd1};

      #22;
      chk("rst_tdo", {63'd0, tdo}, 64'd0);
      chk("rst_tdo_en", {63'd0, tdo_en}, 64'd0);
      chk("rst_req_valid", {63'd0, dtm_req_valid}, 64'd0);
      chk("rst_req_bits", {23'd0, dtm_req_bits}, 64'd0);
      chk("rst_resp_rdy", {63'd0, dtm_resp_ready}, 64'd0);
      rst_n = 1'b1;

      // IDCODE is selected out of reset
      tap_reset();
      scan_dr(32, 41'd0, dout, en_err);
      chk("idcode", {23'd0, dout}, 64'h1000_0A6D);
      chk("idcode_tdo_en", 64'(en_err), 64'd0);

      // DTMCONTROL read
      scan_ir(5'h10, irout);
      chk("ir_capture", {59'd0, irout}, 64'h01);
      scan_dr(32, 41'd0, dout, en_err);
      chk("dtmcs", {23'd0, dout}, 64'h1450);

      // Unknown IR code behaves as 1-bit BYPASS capturing 0
      scan_ir(5'h03, irout);
      scan_dr(2, 41'b01, dout, en_err);
      chk("bypass", {23'd0, dout}, 64'b10);

      // First DBUS request
      scan_ir(5'h11, irout);
      scan_dr(41, v1, dout, en_err);
      chk("dbus_cap0", {23'd0, dout}, 64'd0);
      chk("req_valid", {63'd0, dtm_req_valid}, 64'd1);
      chk("req_bits", {23'd0, dtm_req_bits}, 64'h100_0000_0001);
      for (int i = 0; i < 3; i++) begin
         idle(1);
         chk("req_hold_v", {63'd0, dtm_req_valid}, 64'd1);
         chk("req_hold_b", {23'd0, dtm_req_bits}, 64'h100_0000_0001);
      end
      dtm_req_ready = 1'b1;
      idle(1);
      dtm_req_ready = 1'b0;
      chk("req_done", {63'd0, dtm_req_valid}, 64'd0);
      chk("resp_rdy_busy", {63'd0, dtm_resp_ready}, 64'd1);
      dtm_resp_bits  = {34'h3_0000_0004, 2'd0};
      dtm_resp_valid = 1'b1;
      idle(1);
      dtm_resp_valid = 1'b0;
      chk("resp_rdy_idle", {63'd0, dtm_resp_ready}, 64'd0);
      scan_dr(41, 41'd0, dout, en_err);
      chk("dbus_resp1", {23'd0, dout}, {23'd0, 5'h10, 34'h3_0000_0004, 2'd0});
      chk("nop_no_req", {63'd0, dtm_req_valid}, 64'd0);

      // Second request: handshake it, withhold the response
      scan_dr(41, v2, dout, en_err);
      chk("dbus_cap_r1", {23'd0, dout}, {23'd0, 5'h10, 34'h3_0000_0004, 2'd0});
      chk("req2_bits", {23'd0, dtm_req_bits}, {23'd0, v2});
      dtm_req_ready = 1'b1;
      idle(1);
      dtm_req_ready = 1'b0;
      // Scan while busy: reports busy, is dropped, latches sticky status
      scan_dr(41, v3, dout, en_err);
      chk("busy_cap", {23'd0, dout}, {23'd0, 5'h07, 34'h3_0000_0004, 2'd3});
      chk("busy_no_req", {63'd0, dtm_req_valid}, 64'd0);
      dtm_resp_bits  = {34'h0_1234_5678, 2'd0};
      dtm_resp_valid = 1'b1;
      idle(1);
      dtm_resp_valid = 1'b0;
      scan_dr(41, 41'd0, dout, en_err);
      chk("sticky_cap", {23'd0, dout}, {23'd0, 5'h07, 34'h0_1234_5678, 2'd3});

      // Clear the sticky status through DTMCONTROL
      scan_ir(5'h10, irout);
      scan_dr(32, 41'h0_0001_0000, dout, en_err);
      chk("dtmcs_sticky", {23'd0, dout}, 64'h1750);
      scan_dr(32, 41'd0, dout, en_err);
      chk("dtmcs_clear", {23'd0, dout}, 64'h1450);
      scan_ir(5'h11, irout);
      scan_dr(41, 41'd0, dout, en_err);
      chk("dbus_resp2", {23'd0, dout}, {23'd0, 5'h07, 34'h0_1234_5678, 2'd0});
      scan_dr(41, 41'd0, dout, en_err);
      chk("nop_repeat", {23'd0, dout}, {23'd0, 5'h07, 34'h0_1234_5678, 2'd0});
      chk("nop_no_req2", {63'd0, dtm_req_valid}, 64'd0);

      // Reset in the middle of an outstanding request
      scan_dr(41, v4, dout, en_err);
      chk("req4_valid", {63'd0, dtm_req_valid}, 64'd1);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", {63'd0, dtm_req_valid}, 64'd0);
      chk("mid_rst_bits", {23'd0, dtm_req_bits}, 64'd0);
      chk("mid_rst_rdy", {63'd0, dtm_resp_ready}, 64'd0);
      #10;
      rst_n = 1'b1;
      idle(1);
      scan_dr(32, 41'd0, dout, en_err);
      chk("idcode_post", {23'd0, dout}, 64'h1000_0A6D);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
